// File: rtl/pitch_int_search_pkg.sv
// Shared constants for the adaptive-codebook pitch search blocks.
//   L_INTER4          : lag margin added on each side of the T0_min..T0_max range
//   PIT_SPAN_MAX      : largest legal T0_max - T0_min
//   CORR_MIN          : most negative correlation, the starting maximum of a search
//   CORR_BASE_DEFAULT : default scratch-memory address of the correlation buffer
package pitch_int_search_pkg;

   localparam int unsigned L_INTER4          = 4;
   localparam int unsigned PIT_SPAN_MAX      = 6;
   localparam logic [15:0] CORR_MIN          = 16'h8000;
   localparam logic [11:0] CORR_BASE_DEFAULT = 12'h200;

endpackage

// File: rtl/pitch_int_search_sub.sv
// 16-bit signed saturating subtract: diff_o = sat(a_i - b_i).
// Ports:
//   a_i    : minuend, two's complement
//   b_i    : subtrahend, two's complement
//   diff_o : difference clamped to [16'h8000, 16'h7FFF]; its sign bit is exact
module pitch_int_search_sub (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   output logic [15:0] diff_o
);

   logic [16:0] diff_wide;

   always_comb begin
      diff_wide = {a_i[15], a_i} - {b_i[15], b_i};
      // Bits 16 and 15 disagree only on overflow; bit 16 is the true sign.
      if (diff_wide[16] != diff_wide[15]) begin
         diff_o = diff_wide[16] ? 16'h8000 : 16'h7FFF;
      end else begin
         diff_o = diff_wide[15:0];
      end
   end

endmodule

// File: rtl/pitch_int_search.sv
// Closed-loop integer pitch lag search. Scans corr[] for lags
// T0_min-4 .. T0_max+4 in scratch memory and returns the lag of the largest
// correlation (later lag wins ties) together with that correlation.
// Optional feature macro: PITCH_RANGE_CHECK_EN (adds the rangeErr port and clamps
// an illegal T0_max to T0_min + 6).
// Ports:
//   clock       : system clock, rising edge
//   reset       : synchronous, active-high
//   start       : begin a search, only honoured in the idle state
//   T0_min      : lower lag bound, two's complement
//   T0_max      : upper lag bound, two's complement
//   corrBase    : scratch address of the first correlation entry
//   memIn       : scratch read data, correlation in [15:0] (one-cycle read latency)
//   memReadAddr : scratch read address, 0 outside read cycles
//   T0          : selected lag (registered)
//   maxCorr     : correlation at T0 (registered)
//   done        : one-cycle completion pulse
//   rangeErr    : range violation flag of the last accepted start (macro only)
module pitch_int_search
   import pitch_int_search_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] T0_min,
   input  logic [15:0] T0_max,
   input  logic [11:0] corrBase,
   input  logic [31:0] memIn,
   output logic [11:0] memReadAddr,
   output logic [15:0] T0,
   output logic [15:0] maxCorr,
   output logic        done
`ifdef PITCH_RANGE_CHECK_EN
   ,
   output logic        rangeErr
`endif
);

   typedef enum logic [1:0] {StInit, StRd, StCmp, StDone} state_e;

   state_e      state_q, state_d;
   logic [15:0] idx_q, idx_d;
   logic [15:0] last_q, last_d;   // N - 1
   logic [15:0] t_min_q, t_min_d;
   logic [11:0] base_q, base_d;
   logic [15:0] lag_q, lag_d;
   logic [15:0] max_q, max_d;

   logic [15:0] t0_max_eff;
   logic [15:0] t_min_new;
   logic [15:0] t_max_new;
   logic [15:0] cmp_diff;
   logic        corr_ge;
   logic        unused_mem_hi;

   assign unused_mem_hi = ^memIn[31:16];

`ifdef PITCH_RANGE_CHECK_EN
   logic              range_err_q, range_err_d;
   logic signed [16:0] span;
   logic              range_bad;

   always_comb begin
      span       = $signed({T0_max[15], T0_max}) - $signed({T0_min[15], T0_min});
      range_bad  = (span < 17'sd0) || (span > 17'sd6);
      t0_max_eff = range_bad ? (T0_min + 16'(PIT_SPAN_MAX)) : T0_max;
   end

   assign rangeErr = range_err_q;
`else
   // Unchecked: a reversed range simply wraps through 16-bit arithmetic.
   assign t0_max_eff = T0_max;
`endif

   assign t_min_new = T0_min - 16'(L_INTER4);
   assign t_max_new = t0_max_eff + 16'(L_INTER4);

   // memIn >= max_q exactly when the saturated difference is non-negative.
   pitch_int_search_sub u_sub (
      .a_i    (memIn[15:0]),
      .b_i    (max_q),
      .diff_o (cmp_diff)
   );
   assign corr_ge = ~cmp_diff[15];

   assign T0      = lag_q;
   assign maxCorr = max_q;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      last_d      = last_q;
      t_min_d     = t_min_q;
      base_d      = base_q;
      lag_d       = lag_q;
      max_d       = max_q;
`ifdef PITCH_RANGE_CHECK_EN
      range_err_d = range_err_q;
`endif
      memReadAddr = '0;
      done        = 1'b0;

      case (state_q)
         StInit: begin
            idx_d = '0;
            if (start) begin
               t_min_d     = t_min_new;
               last_d      = t_max_new - t_min_new;
               base_d      = corrBase;
               // The running max starts here so results stay held while idle.
               max_d       = CORR_MIN;
`ifdef PITCH_RANGE_CHECK_EN
               range_err_d = range_bad;
`endif
               state_d     = StRd;
            end
         end
         StRd: begin
            memReadAddr = base_q + idx_q[11:0];
            state_d     = StCmp;
         end
         StCmp: begin
            if (corr_ge) begin
               max_d = memIn[15:0];
               lag_d = t_min_q + idx_q;
            end
            if (idx_q == last_q) begin
               state_d = StDone;
            end else begin
               idx_d   = idx_q + 16'd1;
               state_d = StRd;
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StInit;
         end
         default: state_d = StInit;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StInit;
         idx_q       <= '0;
         last_q      <= '0;
         t_min_q     <= '0;
         base_q      <= '0;
         lag_q       <= '0;
         max_q       <= '0;
`ifdef PITCH_RANGE_CHECK_EN
         range_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         last_q      <= last_d;
         t_min_q     <= t_min_d;
         base_q      <= base_d;
         lag_q       <= lag_d;
         max_q       <= max_d;
`ifdef PITCH_RANGE_CHECK_EN
         range_err_q <= range_err_d;
`endif
      end
   end

endmodule

// File: tb/tb_pitch_int_search.sv
// Directed bench for pitch_int_search with a synchronous-read scratch memory model.
module tb_pitch_int_search;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] T0_min;
   logic [15:0] T0_max;
   logic [11:0] corrBase;
   logic [31:0] memIn;
   logic [11:0] memReadAddr;
   logic [15:0] T0;
   logic [15:0] maxCorr;
   logic        done;
`ifdef PITCH_RANGE_CHECK_EN
   logic        rangeErr;
`endif

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] mem [4096];
   logic [11:0] addr_log [64];
   int          dcyc;

   always #5 clock = ~clock;

   // One-cycle read latency, like the real scratch RAM.
   always @(posedge clock) memIn <= mem[memReadAddr];

   pitch_int_search dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .T0_min      (T0_min),
      .T0_max      (T0_max),
      .corrBase    (corrBase),
      .memIn       (memIn),
      .memReadAddr (memReadAddr),
      .T0          (T0),
      .maxCorr     (maxCorr),
      .done        (done)
`ifdef PITCH_RANGE_CHECK_EN
      ,
      .rangeErr    (rangeErr)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Fill n entries starting at base with val; upper half carries junk.
   task automatic fill(input logic [11:0] base, input int n, input logic [15:0] val);
      for (int k = 0; k < n; k++) mem[12'(base + 12'(k))] = {16'hA5C3, val};
   endtask

   task automatic put(input logic [11:0] base, input int k, input logic [15:0] val);
      mem[12'(base + 12'(k))] = {16'h5A3C, val};
   endtask

   // Start a search; returns the done cycle (start-sampling cycle = 0), or -1.
   // abort_at >= 0 raises reset during that cycle and returns; poke pulses a
   // conflicting start mid-search.
   task automatic run_search(input logic [15:0] tmin, input logic [15:0] tmax,
                             input logic [11:0] base, input int abort_at, input bit poke,
                             output int done_cyc);
      @(negedge clock);
      T0_min   = tmin;
      T0_max   = tmax;
      corrBase = base;
      start    = 1'b1;
      done_cyc = -1;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clock);
         if (c == 1) start = 1'b0;
         if ((c % 2 == 1) && (c < 128)) addr_log[c / 2] = memReadAddr;
         if (done) begin
            done_cyc = c;
            break;
         end
         if (poke && c == 4) begin
            start = 1'b1; T0_min = 16'd0; T0_max = 16'd100; corrBase = 12'h000;
         end
         if (poke && c == 5) start = 1'b0;
         if (c == abort_at) begin
            reset = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      T0_min   = '0;
      T0_max   = '0;
      corrBase = '0;
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;

      repeat (3) @(negedge clock);
      check("rst_T0", 32'(T0), 32'h0);
      check("rst_maxCorr", 32'(maxCorr), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_addr", 32'(memReadAddr), 32'h0);
`ifdef PITCH_RANGE_CHECK_EN
      check("rst_rangeErr", 32'(rangeErr), 32'h0);
`endif
      reset = 1'b0;
      @(negedge clock);
      check("idle_addr", 32'(memReadAddr), 32'h0);

      // Peak in the middle: t_min = 36, entry 7 -> lag 43.
      fill(12'h100, 15, 16'h0000);
      put(12'h100, 7, 16'd100);
      run_search(16'd40, 16'd46, 12'h100, -1, 1'b0, dcyc);
      check("peak_done_cyc", 32'(dcyc), 32'd31);
      check("peak_T0", 32'(T0), 32'd43);
      check("peak_maxCorr", 32'(maxCorr), 32'd100);
      check("peak_addr0", 32'(addr_log[0]), 32'h100);
      check("peak_addr14", 32'(addr_log[14]), 32'h10E);
      @(negedge clock);
      check("peak_done_pulse", 32'(done), 32'h0);
      check("peak_T0_held", 32'(T0), 32'd43);
      check("peak_addr_idle", 32'(memReadAddr), 32'h0);
`ifdef PITCH_RANGE_CHECK_EN
      check("peak_rangeErr", 32'(rangeErr), 32'h0);
`endif

      // Tie: later lag wins; a mid-search start with other inputs is ignored.
      fill(12'h180, 15, 16'hFFFF);
      put(12'h180, 2, 16'd500);
      put(12'h180, 9, 16'd500);
      run_search(16'd40, 16'd46, 12'h180, -1, 1'b1, dcyc);
      check("tie_done_cyc", 32'(dcyc), 32'd31);
      check("tie_T0", 32'(T0), 32'd45);
      check("tie_maxCorr", 32'(maxCorr), 32'd500);

      // All at the most negative value: last entry wins.
      fill(12'h200, 15, 16'h8000);
      run_search(16'd40, 16'd46, 12'h200, -1, 1'b0, dcyc);
      check("min_T0", 32'(T0), 32'd50);
      check("min_maxCorr", 32'(maxCorr), 32'h8000);

      // Address wrap from FFA; peak at entry 10 (address 004) -> lag 46.
      fill(12'hFFA, 15, 16'hFF00);
      put(12'hFFA, 10, 16'd77);
      run_search(16'd40, 16'd46, 12'hFFA, -1, 1'b0, dcyc);
      for (int k = 0; k < 15; k++) begin
         check($sformatf("wrap_addr%0d", k), 32'(addr_log[k]), 32'(12'(12'hFFA + 12'(k))));
      end
      check("wrap_T0", 32'(T0), 32'd46);
      check("wrap_maxCorr", 32'(maxCorr), 32'd77);

      // Reset during cycle 10, then a clean full search.
      run_search(16'd40, 16'd46, 12'h100, 10, 1'b0, dcyc);
      @(negedge clock);
      check("abort_T0", 32'(T0), 32'h0);
      check("abort_maxCorr", 32'(maxCorr), 32'h0);
      check("abort_done", 32'(done), 32'h0);
      check("abort_addr", 32'(memReadAddr), 32'h0);
      reset = 1'b0;
      run_search(16'd40, 16'd46, 12'h100, -1, 1'b0, dcyc);
      check("rerun_done_cyc", 32'(dcyc), 32'd31);
      check("rerun_T0", 32'(T0), 32'd43);
      check("rerun_maxCorr", 32'(maxCorr), 32'd100);

      // Oversized range 50..60: entry 14 = 200, entry 18 = 300.
      fill(12'h300, 20, 16'h0000);
      put(12'h300, 14, 16'd200);
      put(12'h300, 18, 16'd300);
      run_search(16'd50, 16'd60, 12'h300, -1, 1'b0, dcyc);
`ifdef PITCH_RANGE_CHECK_EN
      check("range_done_cyc", 32'(dcyc), 32'd31);
      check("range_T0", 32'(T0), 32'd60);
      check("range_maxCorr", 32'(maxCorr), 32'd200);
      check("range_err", 32'(rangeErr), 32'h1);
`else
      check("range_done_cyc", 32'(dcyc), 32'd39);
      check("range_T0", 32'(T0), 32'd64);
      check("range_maxCorr", 32'(maxCorr), 32'd300);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
